note_player_env: RTL and testbench
==================================

// Module: note_player_env
// PURPOSE
//  Parametrised note player with per-sample amplitude envelope (attack/sustain/release), rests and legato mode.
//  Loads a note+duration, counts 1/48 s beats, drives frequency_rom + sine_reader, scales samples by envelope.
//  Sits between song_reader/music_player control and the codec sample path; one instance per voice.
// PARAMETERS
//  NOTE_W        6   note index width; note 0 = rest
//  DUR_W         6   duration width, in beats
//  STEP_W        20  frequency_rom step-size width
//  SAMPLE_W      16  signed sample width (sine_reader output and sample_out)
//  ENV_W         8   envelope fraction bits; unity gain = 1<<ENV_W
//  ATTACK_STEP   16  level increment per generated sample in ATTACK
//  RELEASE_STEP  8   level decrement per generated sample in RELEASE
//  RELEASE_BEATS 2   release begins when remaining beats <= RELEASE_BEATS
//  LEGATO        0   1: envelope level kept across back-to-back loads; 0: level restarts at 0
// PORTS
//  clk                  in   1          system clock, single domain
//  reset                in   1          asynchronous, active-low reset
//  play_enable          in   1          1: play/count; 0: freeze counter, envelope, sample requests
//  note_to_load         in   NOTE_W     note index captured on load
//  duration_to_load     in   DUR_W      duration in beats captured on load
//  load_new_note        in   1          1-cycle strobe: capture note/duration, start note
//  beat                 in   1          1-cycle strobe at 48 Hz
//  generate_next_sample in   1          codec sample request strobe
//  done_with_note       out  1          1-cycle pulse on the beat that ends the note
//  note_busy            out  1          high while state != IDLE
//  env_level            out  ENV_W+1    current envelope level, 0..(1<<ENV_W)
//  sample_out           out  SAMPLE_W   enveloped signed sample
//  new_sample_ready     out  1          1-cycle strobe: sample_out valid
// BEHAVIOUR
//  - Reset (reset==0, async): state IDLE, beat counter 0, note reg 0, env_level 0, all outputs 0.
//  - States: IDLE, ATTACK, SUSTAIN, RELEASE. Beat counter rem (DUR_W bits) = beats remaining.
//  - load_new_note (accepted regardless of play_enable): note reg <= note_to_load,
//    rem <= (duration_to_load==0 ? 1 : duration_to_load); state -> ATTACK;
//    level <= 0 unless LEGATO==1 and state!=IDLE (then level held).
//  - load and beat in same cycle: load wins, beat ignored. done_with_note not asserted.
//  - Beat (play_enable=1, state!=IDLE, no load): if rem==1 -> done_with_note=1 that cycle,
//    rem<=0, state->IDLE, level->0; else rem<=rem-1. No done pulse in IDLE.
//  - Release entry: any non-IDLE state with rem<=RELEASE_BEATS -> RELEASE (checked every cycle).
//  - Envelope updates only on accepted sample requests (generate_next_sample & play_enable & state!=IDLE):
//    ATTACK: level += ATTACK_STEP, saturate at 1<<ENV_W -> SUSTAIN when reached.
//    SUSTAIN: hold. RELEASE: level -= RELEASE_STEP, saturate at 0.
//  - Sample path: sine_reader.generate_next = generate_next_sample & play_enable & state!=IDLE.
//    On sine_reader sample_ready: sample_out <= (sine * $signed({1'b0,level})) >>> ENV_W (arithmetic,
//    truncate toward -inf, result fits SAMPLE_W since level<=unity); new_sample_ready 1 cycle later.
//    Rest (note reg==0): sample_out <= 0 but new_sample_ready still strobes; counter/envelope run normally.
//  - IDLE: no requests forwarded, new_sample_ready stays 0, sample_out holds last value.
//  - play_enable=0: rem, state, level frozen; pending beats are dropped, not queued.
//  - reset mid-note: immediate return to reset values; no done pulse.
// STRUCTURE
//  - Shared include note_player_defs.vh: state encodings (IDLE/ATTACK/SUSTAIN/RELEASE), NOTE_REST=0.
//  - Sub-module note_envelope: state machine + level saturating arithmetic; top holds note/duration regs,
//    frequency_rom, sine_reader, output multiply register. Registers use async active-low flops.
// TESTING
//  1 reset=0 mid-note -> all outputs 0, note_busy=0; release reset, 10 beats -> no done pulse.
//  2 load note=6'd20,dur=4, defaults, play_enable=1 -> done_with_note on 4th beat exactly, note_busy falls.
//  3 attack: ATTACK_STEP=16 -> env_level 16,32,..,256 after 16 accepted requests, then SUSTAIN; full-scale
//    sine sample 16'h7FFF at unity -> sample_out 16'h7FFF; at level 128 -> 16'h3FFF.
//  4 rest: note=0,dur=3 -> sample_out=0 with new_sample_ready strobes; done on 3rd beat.
//  5 play_enable=0 for 5 beats mid-note -> rem/env_level unchanged, no new_sample_ready; resumes correctly.
//  6 load coincident with beat at rem=1 -> no done pulse, new duration loaded; LEGATO=1 keeps env_level,
//    LEGATO=0 restarts at 0; duration_to_load=0 -> done on first beat.

Source files
------------

// File: rtl/note_player_env_pkg.sv
// Shared types and helpers for the note player voice: envelope states and a
// 16-entry full-wave sine table used by the built-in sine reader.
package note_player_env_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAttack,
    StSustain,
    StRelease
  } env_state_e;

  // Q15 sine, one entry per 1/16 turn.
  function automatic logic signed [15:0] sine_lut(input logic [3:0] idx);
    logic signed [15:0] val;
    case (idx)
      4'd0:    val = 16'sd0;
      4'd1:    val = 16'sd12539;
      4'd2:    val = 16'sd23170;
      4'd3:    val = 16'sd30273;
      4'd4:    val = 16'sd32767;
      4'd5:    val = 16'sd30273;
      4'd6:    val = 16'sd23170;
      4'd7:    val = 16'sd12539;
      4'd8:    val = 16'sd0;
      4'd9:    val = -16'sd12539;
      4'd10:   val = -16'sd23170;
      4'd11:   val = -16'sd30273;
      4'd12:   val = -16'sd32767;
      4'd13:   val = -16'sd30273;
      4'd14:   val = -16'sd23170;
      default: val = -16'sd12539;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/note_envelope.sv
// Note lifetime state machine: beat countdown, attack/sustain/release envelope
// with saturating level arithmetic, done pulse on the final beat.
module note_envelope
  import note_player_env_pkg::*;
#(
  parameter int unsigned DUR_W         = 6,
  parameter int unsigned ENV_W         = 8,
  parameter int unsigned ATTACK_STEP   = 16,
  parameter int unsigned RELEASE_STEP  = 8,
  parameter int unsigned RELEASE_BEATS = 2,
  parameter int unsigned LEGATO        = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             play_enable,
  input  logic             load,
  input  logic             beat,
  input  logic             sample_req,
  input  logic [DUR_W-1:0] dur_load,
  output logic             done,
  output logic             busy,
  output logic             accept,
  output logic [ENV_W:0]   level
);

  localparam logic [ENV_W:0] Unity    = {1'b1, {ENV_W{1'b0}}};
  localparam logic [ENV_W:0] AStep    = (ENV_W+1)'(ATTACK_STEP);
  localparam logic [ENV_W:0] RStep    = (ENV_W+1)'(RELEASE_STEP);
  localparam logic [DUR_W-1:0] RemOne = DUR_W'(1);
  localparam logic [DUR_W-1:0] RelBeats = DUR_W'(RELEASE_BEATS);

  env_state_e       state_q, state_d;
  logic [DUR_W-1:0] rem_q, rem_d;
  logic [ENV_W:0]   level_q, level_d;

  assign busy   = (state_q != StIdle);
  assign accept = sample_req & play_enable & busy;
  assign level  = level_q;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    level_d = level_q;
    done    = 1'b0;
    if (load) begin
      // A load always wins over a coincident beat.
      state_d = StAttack;
      rem_d   = (dur_load == '0) ? RemOne : dur_load;
      if (!(LEGATO != 0 && busy)) level_d = '0;
    end else if (play_enable && busy) begin
      if (sample_req) begin
        case (state_q)
          StAttack: begin
            if (level_q >= Unity - AStep) begin
              level_d = Unity;
              state_d = StSustain;
            end else begin
              level_d = level_q + AStep;
            end
          end
          StRelease: level_d = (level_q > RStep) ? level_q - RStep : '0;
          default: ;
        endcase
      end
      if (rem_q <= RelBeats) state_d = StRelease;
      if (beat) begin
        if (rem_q == RemOne) begin
          done    = 1'b1;
          rem_d   = '0;
          state_d = StIdle;
          level_d = '0;
        end else begin
          rem_d = rem_q - RemOne;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rem_q   <= '0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/note_player_env.sv
// One voice: note register, phase-accumulator sine reader driven by a note-derived
// step, and a registered envelope multiply feeding the codec sample path.
module note_player_env
  import note_player_env_pkg::*;
#(
  parameter int unsigned NOTE_W        = 6,
  parameter int unsigned DUR_W         = 6,
  parameter int unsigned STEP_W        = 20,
  parameter int unsigned SAMPLE_W      = 16,
  parameter int unsigned ENV_W         = 8,
  parameter int unsigned ATTACK_STEP   = 16,
  parameter int unsigned RELEASE_STEP  = 8,
  parameter int unsigned RELEASE_BEATS = 2,
  parameter int unsigned LEGATO        = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                play_enable,
  input  logic [NOTE_W-1:0]   note_to_load,
  input  logic [DUR_W-1:0]    duration_to_load,
  input  logic                load_new_note,
  input  logic                beat,
  input  logic                generate_next_sample,
  output logic                done_with_note,
  output logic                note_busy,
  output logic [ENV_W:0]      env_level,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                new_sample_ready
);

  localparam logic [NOTE_W-1:0] NoteRest = '0;

  logic                            accept;
  logic [NOTE_W-1:0]               note_q;
  logic [STEP_W-1:0]               phase_q, step, phase_next;
  logic signed [SAMPLE_W-1:0]      sine_q, scaled;
  logic                            sine_ready_q;
  logic [SAMPLE_W-1:0]             sample_q;
  logic                            nsr_q;
  logic signed [SAMPLE_W+ENV_W+1:0] prod;

  note_envelope #(
    .DUR_W         (DUR_W),
    .ENV_W         (ENV_W),
    .ATTACK_STEP   (ATTACK_STEP),
    .RELEASE_STEP  (RELEASE_STEP),
    .RELEASE_BEATS (RELEASE_BEATS),
    .LEGATO        (LEGATO)
  ) u_env (
    .clk         (clk),
    .rst_n       (reset),
    .play_enable (play_enable),
    .load        (load_new_note),
    .beat        (beat),
    .sample_req  (generate_next_sample),
    .dur_load    (duration_to_load),
    .done        (done_with_note),
    .busy        (note_busy),
    .accept      (accept),
    .level       (env_level)
  );

  // Frequency table: step grows linearly with note index.
  assign step       = STEP_W'(note_q) << (STEP_W - NOTE_W - 1);
  assign phase_next = phase_q + step;

  // Level is non-negative and at most unity, so the scaled value fits SAMPLE_W.
  assign prod   = sine_q * $signed({1'b0, env_level});
  assign scaled = SAMPLE_W'(prod >>> ENV_W);

  assign sample_out       = sample_q;
  assign new_sample_ready = nsr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      note_q       <= '0;
      phase_q      <= '0;
      sine_q       <= '0;
      sine_ready_q <= 1'b0;
      sample_q     <= '0;
      nsr_q        <= 1'b0;
    end else begin
      sine_ready_q <= accept;
      nsr_q        <= sine_ready_q;
      if (load_new_note) begin
        note_q  <= note_to_load;
        phase_q <= '0;
      end else if (accept) begin
        phase_q <= phase_next;
        sine_q  <= SAMPLE_W'(sine_lut(phase_next[STEP_W-1 -: 4]));
      end
      if (sine_ready_q) sample_q <= (note_q == NoteRest) ? '0 : scaled;
    end
  end

endmodule

// File: tb/tb_note_player_env.sv
// Directed bench for note_player_env: default voice plus a legato voice on shared stimulus.
module tb_note_player_env;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       play_enable = 1'b0;
  logic [5:0] note_to_load = '0;
  logic [5:0] duration_to_load = '0;
  logic       load_new_note = 1'b0;
  logic       beat = 1'b0;
  logic       gen = 1'b0;

  logic        done0, busy0, nsr0, done1, busy1, nsr1;
  logic [8:0]  env0, env1;
  logic [15:0] samp0, samp1;

  int n_total = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  note_player_env dut (
    .clk                  (clk),
    .reset                (reset),
    .play_enable          (play_enable),
    .note_to_load         (note_to_load),
    .duration_to_load     (duration_to_load),
    .load_new_note        (load_new_note),
    .beat                 (beat),
    .generate_next_sample (gen),
    .done_with_note       (done0),
    .note_busy            (busy0),
    .env_level            (env0),
    .sample_out           (samp0),
    .new_sample_ready     (nsr0)
  );

  note_player_env #(.LEGATO(1)) dut_leg (
    .clk                  (clk),
    .reset                (reset),
    .play_enable          (play_enable),
    .note_to_load         (note_to_load),
    .duration_to_load     (duration_to_load),
    .load_new_note        (load_new_note),
    .beat                 (beat),
    .generate_next_sample (gen),
    .done_with_note       (done1),
    .note_busy            (busy1),
    .env_level            (env1),
    .sample_out           (samp1),
    .new_sample_ready     (nsr1)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_note(input logic [5:0] n, input logic [5:0] d);
    note_to_load = n;
    duration_to_load = d;
    load_new_note = 1'b1;
    tick();
    load_new_note = 1'b0;
  endtask

  // done is sampled mid-cycle while the beat strobe is high.
  task automatic do_beat(input logic with_load, output logic d0, output logic d1);
    beat = 1'b1;
    load_new_note = with_load;
    @(negedge clk);
    d0 = done0;
    d1 = done1;
    tick();
    beat = 1'b0;
    load_new_note = 1'b0;
  endtask

  // Returns when the enveloped sample of this request is on sample_out.
  task automatic do_req();
    gen = 1'b1;
    tick();
    gen = 1'b0;
    tick();
  endtask

  initial begin
    logic d0, d1;
    int cnt;
    play_enable = 1'b1;

    // Reset values
    #2;
    check_val("rst_done", done0, 0);
    check_val("rst_busy", busy0, 0);
    check_val("rst_env", env0, 0);
    check_val("rst_sample", samp0, 0);
    check_val("rst_nsr", nsr0, 0);
    tick();
    reset = 1'b1;

    // Reset mid-note
    load_note(6'd4, 6'd20);
    do_req();
    do_req();
    check_val("pre_rst_env", env0, 32);
    check_val("pre_rst_sample", samp0, 16'd1567);
    #3 reset = 1'b0;
    #1;
    check_val("midrst_busy", busy0, 0);
    check_val("midrst_env", env0, 0);
    check_val("midrst_sample", samp0, 0);
    check_val("midrst_nsr", nsr0, 0);
    tick();
    reset = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      do_beat(1'b0, d0, d1);
      cnt += int'(d0);
    end
    check_val("after_rst_no_done", cnt, 0);

    // Four-beat note
    load_note(6'd20, 6'd4);
    check_val("dur4_busy", busy0, 1);
    for (int i = 0; i < 4; i++) begin
      do_beat(1'b0, d0, d1);
      check_val("dur4_done", d0, (i == 3));
    end
    check_val("dur4_busy_end", busy0, 0);
    check_val("dur4_env_end", env0, 0);
    do_req();
    check_val("idle_no_nsr", nsr0, 0);

    // Attack ramp, sustain, release
    load_note(6'd4, 6'd20);
    for (int k = 1; k <= 40; k++) begin
      do_req();
      check_val("attack_env", env0, (k < 16) ? 16 * k : 256);
      if (k == 1) check_val("attack_nsr", nsr0, 1);
      if (k == 2) check_val("attack_s2", samp0, 16'd1567);
      if (k == 8) check_val("half_7fff", samp0, 16'h3FFF);
      if (k == 24) check_val("unity_neg", samp0, 16'h8001);
      if (k == 40) check_val("unity_7fff", samp0, 16'h7FFF);
    end
    cnt = 0;
    for (int i = 0; i < 18; i++) begin
      do_beat(1'b0, d0, d1);
      cnt += int'(d0);
    end
    check_val("dur20_no_early_done", cnt, 0);
    tick();
    do_req();
    check_val("release_env", env0, 248);
    check_val("release_sample", samp0, 16'h7BFF);
    do_beat(1'b0, d0, d1);
    check_val("dur20_beat19", d0, 0);
    do_beat(1'b0, d0, d1);
    check_val("dur20_beat20", d0, 1);

    // Rest
    load_note(6'd0, 6'd3);
    do_req();
    check_val("rest_nsr", nsr0, 1);
    check_val("rest_sample", samp0, 0);
    check_val("rest_env", env0, 16);
    for (int i = 0; i < 3; i++) begin
      do_beat(1'b0, d0, d1);
      check_val("rest_done", d0, (i == 2));
    end

    // Pause mid-note
    load_note(6'd4, 6'd10);
    for (int k = 0; k < 4; k++) do_req();
    check_val("pause_env_before", env0, 64);
    play_enable = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      do_beat(1'b0, d0, d1);
      cnt += int'(d0);
    end
    check_val("pause_no_done", cnt, 0);
    do_req();
    check_val("pause_no_nsr", nsr0, 0);
    check_val("pause_env_held", env0, 64);
    play_enable = 1'b1;
    do_req();
    check_val("resume_env", env0, 80);
    check_val("resume_sample", samp0, 16'h1C48);
    for (int i = 0; i < 10; i++) begin
      do_beat(1'b0, d0, d1);
      check_val("resume_done", d0, (i == 9));
    end

    // Load coincident with final beat; legato vs restart
    load_note(6'd4, 6'd3);
    for (int k = 0; k < 3; k++) do_req();
    check_val("legato_env_pre", env1, 48);
    do_beat(1'b0, d0, d1);
    do_beat(1'b0, d0, d1);
    note_to_load = 6'd4;
    duration_to_load = 6'd5;
    do_beat(1'b1, d0, d1);
    check_val("coinc_no_done", d0, 0);
    check_val("coinc_no_done_leg", d1, 0);
    check_val("coinc_env_restart", env0, 0);
    check_val("coinc_env_legato", env1, 48);
    check_val("coinc_busy", busy0, 1);
    for (int i = 0; i < 5; i++) begin
      do_beat(1'b0, d0, d1);
      check_val("newdur_done", d0, (i == 4));
      check_val("newdur_done_leg", d1, (i == 4));
    end
    load_note(6'd4, 6'd0);
    do_beat(1'b0, d0, d1);
    check_val("dur0_done", d0, 1);
    check_val("dur0_busy", busy0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
